quad_decoder: RTL
=================

Name: quad_decoder

Overview:
- Input-side companion to the LED counter: reads a two-channel quadrature (rotary) encoder and turns it into an up/down count plus direction.
- Encoder pins are synchronized, sampled on a divided tick and debounced, then Gray-decoded at x4 resolution.
- Outputs are a wrapping count, a one-cycle step strobe, a held direction flag and an illegal-transition error strobe.
- Sits between the board encoder pins and the counter/LED logic.

Parameters:
WIDTH, 4, count output width; count wraps modulo 2^WIDTH
DIV, 5, sample tick period in clk cycles (DIV >= 1; DIV = 1 gives a tick every cycle)
STABLE, 3, consecutive equal samples required before a channel's filtered value changes (STABLE >= 1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
enc_a  input  1  encoder channel A, asynchronous to clk
enc_b  input  1  encoder channel B, asynchronous to clk
count  output  WIDTH  decoded position
step  output  1  one-cycle pulse per counted transition
dir  output  1  direction of last counted step: 1 = up, 0 = down
err  output  1  one-cycle pulse on an illegal transition (both channels changed)

Behaviour:
- Reset (reset low, takes effect immediately, not clocked):
  - count = 0, step = 0, dir = 1, err = 0.
  - Synchronizer flops, candidates, filtered values = 0; divider = 0; stability counters = 0; FSM = INIT.
- Synchronizer: 2 flops per channel. Nothing downstream uses the raw pins.
- Tick: divider counts 0..DIV-1 and wraps; tick = (divider == DIV-1), one cycle wide.
- Debounce (per channel, evaluated on tick only):
  - If the synced value differs from the candidate: candidate <= synced, stab_cnt <= 0.
  - Otherwise, if stab_cnt < STABLE-1: stab_cnt increments.
  - A channel is "stable" when stab_cnt == STABLE-1. The filtered value loads the candidate on the tick where the channel becomes or remains stable.
  - A pulse shorter than STABLE ticks never reaches the filtered value.
- FSM (2 states):
  - INIT: on the first tick where both channels are stable, load prev = {filt_a, filt_b} and go to TRACK. No step or err is produced in INIT, so any encoder resting position after reset is legal.
  - TRACK: each cycle compares cur = {filt_a, filt_b} against prev. If different, prev <= cur and the transition is classified as:
    - Up (00->01, 01->11, 11->10, 10->00): count+1 mod 2^WIDTH, dir <= 1, step pulses.
    - Down (reverse of the above): count-1 mod 2^WIDTH, dir <= 0, step pulses.
    - Illegal (00<->11, 01<->10): count and dir unchanged, err pulses, step stays 0.
- Latency: step, err, count and dir update in the cycle after the filtered value changes; all are registered outputs.
- Wrap-around: 15 + up = 0 and 0 + down = 15 at WIDTH = 4. No saturation.
- dir holds its value between steps.
- step and err are never high in the same cycle.
- Reset asserted mid-operation: everything returns to reset values at once. After release the block re-enters INIT, and count restarts at 0.

Decomposition:
- Package quad_pkg holds:
  - typedef enum state_t {INIT, TRACK}.
  - typedef logic [1:0] quad_t.
  - Gray sequence constants Q00, Q01, Q11, Q10.
  - A function classify(prev, cur) returning NONE / UP / DOWN / ILLEGAL.
- One sub-module, quad_debounce: synchronizer, stability counter and filtered output for a single channel, driven by the shared tick. It is instantiated twice, once per channel.
- The top level holds the divider, FSM, decode and count register.

Test Plan (WIDTH=4, DIV=5, STABLE=3, 10 ns clock):
1. Hold reset low 10 cycles with a=b=0, then release.
   -> All outputs at reset values; FSM reaches TRACK within ~20 cycles; no step or err; count = 0, dir = 1.
2. Drive a,b through 01, 11, 10, 00, each held 20 ticks.
   -> Exactly 4 step pulses; count = 4; dir = 1; err never asserted.
3. From count = 0, drive 00 -> 10.
   -> One step pulse; count = 15 (wrap); dir = 0. Continuing with 11, 01, 00 gives count = 12.
4. Toggle a high for 2 ticks (10 cycles), then back to 0.
   -> No step, no err; count and dir unchanged.
5. From state 00, drive 11 and hold.
   -> One err pulse; count unchanged; no step. A following 11 -> 10 gives step and count+1, dir = 1.
6. Assert reset mid-sequence with count = 7, and release with the encoder resting at 11.
   -> Outputs reset immediately (count = 0, dir = 1); after INIT, no err is raised. A following 11 -> 10 gives count = 1.

Source files
------------

// File: rtl/quad_pkg.sv
// quad_pkg: shared types, Gray constants and transition classifier for quad_decoder
package quad_pkg;
  typedef enum logic {INIT, TRACK} state_t;
  typedef enum logic [1:0] {NONE, UP, DOWN, ILLEGAL} cls_t;
  typedef logic [1:0] quad_t;
  localparam quad_t Q00 = 2'b00;
  localparam quad_t Q01 = 2'b01;
  localparam quad_t Q11 = 2'b11;
  localparam quad_t Q10 = 2'b10;
  function automatic logic [1:0] gray_pos(quad_t q);
    return q == Q00 ? 2'd0 : q == Q01 ? 2'd1 : q == Q11 ? 2'd2 : 2'd3;
  endfunction
  function automatic cls_t classify(quad_t prev, quad_t cur);
    logic [1:0] d;
    d = gray_pos(cur) - gray_pos(prev);
    return d == 2'd0 ? NONE : d == 2'd1 ? UP : d == 2'd3 ? DOWN : ILLEGAL;
  endfunction
endpackage

// File: rtl/quad_debounce.sv
// quad_debounce: per-channel 2-flop synchronizer and tick-sampled debounce filter
// Ports: clk, reset (async active-low), tick (sample strobe), d (raw pin), filt (debounced), stable
module quad_debounce #(
  parameter int STABLE = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic d,
  output logic filt,
  output logic stable
);
  localparam int CW = $clog2(STABLE + 1);
  localparam logic [CW-1:0] TOP = CW'(STABLE - 1);
  logic [1:0] sync;
  logic cand;
  logic [CW-1:0] cnt, cnt_n;
  assign stable = cnt == TOP;
  // candidate always follows the synced value on a tick, so only the counter needs a next-state
  always_comb cnt_n = sync[1] != cand ? '0 : cnt == TOP ? cnt : cnt + CW'(1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync <= '0;
      cand <= 1'b0;
      cnt  <= '0;
      filt <= 1'b0;
    end else begin
      sync <= {sync[0], d};
      if (tick) begin
        cand <= sync[1];
        cnt  <= cnt_n;
        if (cnt_n == TOP) filt <= sync[1];
      end
    end
  end
endmodule

// File: rtl/quad_decoder.sv
// quad_decoder: debounced x4 quadrature decoder producing wrapping count, step, dir and err
// Ports: clk, reset (async active-low), enc_a/enc_b (raw pins), count, step, dir (1 = up), err
module quad_decoder
  import quad_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DIV    = 5,
  parameter int STABLE = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  output logic [WIDTH-1:0] count,
  output logic             step,
  output logic             dir,
  output logic             err
);
  localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
  logic [DW-1:0] div;
  logic tick, fa, fb, sa, sb;
  state_t state, state_n;
  quad_t prev, prev_n, cur;
  cls_t cls;
  logic [WIDTH-1:0] count_n;
  logic step_n, dir_n, err_n;
  assign tick = div == DW'(DIV - 1);
  assign cur  = {fa, fb};
  assign cls  = classify(prev, cur);
  quad_debounce #(.STABLE(STABLE)) u_a (.clk(clk), .reset(reset), .tick(tick), .d(enc_a), .filt(fa), .stable(sa));
  quad_debounce #(.STABLE(STABLE)) u_b (.clk(clk), .reset(reset), .tick(tick), .d(enc_b), .filt(fb), .stable(sb));
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div   <= '0;
      state <= INIT;
      prev  <= Q00;
      count <= '0;
      step  <= 1'b0;
      dir   <= 1'b1;
      err   <= 1'b0;
    end else begin
      div   <= tick ? '0 : div + DW'(1);
      state <= state_n;
      prev  <= prev_n;
      count <= count_n;
      step  <= step_n;
      dir   <= dir_n;
      err   <= err_n;
    end
  end
  // INIT adopts whatever resting position the encoder settles at, so no event is raised for it
  always_comb begin
    state_n = state;
    prev_n  = prev;
    count_n = count;
    dir_n   = dir;
    step_n  = 1'b0;
    err_n   = 1'b0;
    if (state == INIT) begin
      if (tick && sa && sb) begin
        state_n = TRACK;
        prev_n  = cur;
      end
    end else if (cls != NONE) begin
      prev_n  = cur;
      step_n  = cls != ILLEGAL;
      err_n   = cls == ILLEGAL;
      dir_n   = cls == UP ? 1'b1 : cls == DOWN ? 1'b0 : dir;
      count_n = cls == UP ? count + WIDTH'(1) : cls == DOWN ? count - WIDTH'(1) : count;
    end
  end
endmodule
